// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter: shares the register-file port between the core and a host,
// giving the host idle core cycles and forcing a one-cycle core stall after MAX_WAIT contended cycles.
module regfile_port_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int AW       = 7,
    parameter int DW       = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          core_active,
    input  logic [AW-1:0] core_rd_addr,
    input  logic [AW-1:0] core_wr_addr,
    input  logic          core_wr_en,
    input  logic [DW-1:0] core_din,
    output logic          core_stall,
    output logic          core_rd_void,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_wr_addr,
    output logic [AW-1:0] mem_rd_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);
    localparam int WW = MAX_WAIT > 0 ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);

    logic [WW-1:0] wait_cnt;
    logic          rd_pend;
    logic          cap_pend;
    logic          host_own;

    assign host_own     = host_req && (!core_active || wait_cnt == WMAX);
    assign host_gnt     = host_own;
    assign core_stall   = host_own && core_active;
    assign core_rd_void = rd_pend;
    assign host_rvalid  = cap_pend;
    assign mem_rd_addr  = host_own ? host_addr : core_rd_addr;
    assign mem_wr_addr  = host_own ? host_addr : core_wr_addr;
    assign mem_din      = host_own ? host_wdata : core_din;
    // rst gates the strobe so nothing is written while reset is held
    assign mem_wr_en    = rst && (host_own ? host_we : core_wr_en && core_active);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt   <= '0;
            rd_pend    <= 1'b0;
            cap_pend   <= 1'b0;
            host_rdata <= '0;
        end else begin
            wait_cnt   <= (!host_req || host_own) ? '0 :
                          (core_active && wait_cnt != WMAX) ? wait_cnt + 1'b1 : wait_cnt;
            rd_pend    <= host_own && !host_we;
            cap_pend   <= rd_pend;
            if (rd_pend)
                host_rdata <= mem_dout;
        end
    end
endmodule
